apb_master_arbiter: RTL and testbench

//  Shares one APB master port between NUM_REQ requesters (test sequencers, register-init

---
 rtl/apb_arb_pkg.sv | 6 +
 rtl/rr_arbiter.sv | 24 ++
 rtl/apb_master_arbiter.sv | 90 +++++++++
 tb/tb_apb_master_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared APB arbiter state type and default bus widths
package apb_arb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning from ptr+1 upward with wrap
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  logic hit;
  always_comb begin
    hit = 1'b0;
    gnt_idx = '0;
    for (int k = N; k >= 1; k--)
      for (int i = 0; i < N; i++)
        if (en && req[i] && i == (int'(ptr) + k) % N) begin
          hit = 1'b1;
          gnt_idx = IW'(i);
        end
    for (int i = 0; i < N; i++) gnt[i] = hit && gnt_idx == IW'(i);
  end
endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin sharing of one zero-wait-state APB master port
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  apb_state_e state_q, state_d;
  logic [IW-1:0] last_q, last_d, owner_q, owner_d, gnt_idx;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic pwrite_q, pwrite_d;
  logic [NUM_REQ-1:0] gnt, rsp_valid_q, rsp_valid_d;
  logic window;
  assign window = !rst && state_q != SETUP;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req(req_valid),
    .en(window),
    .ptr(last_q),
    .gnt(gnt),
    .gnt_idx(gnt_idx)
  );
  assign req_ready = gnt;
  assign psel = state_q != IDLE;
  assign penable = state_q == ACCESS;
  assign pwrite = pwrite_q;
  assign paddr = paddr_q;
  assign pwdata = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  always_comb begin
    state_d = state_q == SETUP ? ACCESS : IDLE;
    last_d = last_q;
    owner_d = owner_q;
    paddr_d = state_q == SETUP ? paddr_q : '0;
    pwdata_d = state_q == SETUP ? pwdata_q : '0;
    pwrite_d = state_q == SETUP ? pwrite_q : 1'b0;
    rsp_rdata_d = state_q == ACCESS ? (pwrite_q ? '0 : prdata) : rsp_rdata_q;
    for (int i = 0; i < NUM_REQ; i++) rsp_valid_d[i] = state_q == ACCESS && owner_q == IW'(i);
    if (|gnt) begin
      state_d = SETUP;
      last_d = gnt_idx;
      owner_d = gnt_idx;
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) begin
        paddr_d = req_addr[i*ADDR_W +: ADDR_W];
        pwdata_d = req_wdata[i*DATA_W +: DATA_W];
        pwrite_d = req_write[i];
      end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      last_q <= IW'(NUM_REQ - 1);
      owner_q <= '0;
      paddr_q <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      owner_q <= owner_d;
      paddr_q <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed scenarios plus randomized timeline-model checking
module tb_apb_master_arbiter;
  localparam int N = 2, AW = 8, DW = 32, NC = 400;
  logic clk = 1'b0, rst;
  logic [N-1:0] req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, pwdata, prdata;
  logic psel, penable, pwrite;
  logic [AW-1:0] paddr;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  apb_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_write[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    req_valid = '1;
    req_write = '0;
    req_addr = '0;
    req_wdata = '0;
    prdata = '0;
    tick;
    tick;
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    checks++; if ({psel, penable, pwrite, paddr, pwdata} !== '0) begin failures++; $display("FAIL reset_bus got=%b%b%b %h %h exp=all zero", psel, penable, pwrite, paddr, pwdata); end
    checks++; if ({rsp_valid, rsp_rdata} !== '0) begin failures++; $display("FAIL reset_rsp got=%b %h exp=00 0", rsp_valid, rsp_rdata); end
    rst = 1'b0;
    req_valid = '0;
    tick;
  endtask
  task automatic test_single_write;
    set_req(0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL wr_ready got=%b exp=01", req_ready); end
    tick;
    req_valid[0] = 1'b0;
    checks++; if ({psel, penable, paddr} !== {2'b10, 8'h10}) begin failures++; $display("FAIL wr_setup got=%b%b %h exp=10 10", psel, penable, paddr); end
    tick;
    checks++; if ({psel, penable, pwrite, pwdata} !== {3'b111, 32'hDEADBEEF}) begin failures++; $display("FAIL wr_access got=%b%b%b %h exp=111 deadbeef", psel, penable, pwrite, pwdata); end
    tick;
    checks++; if ({rsp_valid, psel, rsp_rdata} !== {2'b01, 1'b0, 32'h0}) begin failures++; $display("FAIL wr_rsp got=%b %b %h exp=01 0 0", rsp_valid, psel, rsp_rdata); end
    tick;
  endtask
  task automatic test_single_read;
    set_req(1, 1'b1, 1'b0, 8'h04, 32'h0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL rd_ready got=%b exp=10", req_ready); end
    tick;
    req_valid[1] = 1'b0;
    tick;
    checks++; if ({psel, penable, pwrite, paddr} !== {3'b110, 8'h04}) begin failures++; $display("FAIL rd_access got=%b%b%b %h exp=110 04", psel, penable, pwrite, paddr); end
    prdata = 32'hA5A50001;
    tick;
    prdata = '0;
    checks++; if ({rsp_valid, rsp_rdata} !== {2'b10, 32'hA5A50001}) begin failures++; $display("FAIL rd_rsp got=%b %h exp=10 a5a50001", rsp_valid, rsp_rdata); end
    tick;
  endtask
  task automatic test_contention;
    logic [AW-1:0] ea [N];
    int w;
    for (int i = 0; i < N; i++) begin
      ea[i] = AW'($urandom);
      set_req(i, 1'b1, 1'b1, ea[i], $urandom);
    end
    for (int g = 0; g < 4; g++) begin
      w = g % 2;
      @(negedge clk);
      checks++; if (req_ready !== N'(1 << w)) begin failures++; $display("FAIL cont_grant%0d got=%b exp=%0d", g, req_ready, w); end
      tick;
      checks++; if ({psel, penable, paddr} !== {2'b10, ea[w]}) begin failures++; $display("FAIL cont_setup%0d got=%b%b %h exp=10 %h", g, psel, penable, paddr, ea[w]); end
      if (g > 0) begin
        checks++; if (rsp_valid !== N'(1 << (1 - w))) begin failures++; $display("FAIL cont_rsp%0d got=%b exp=%0d", g, rsp_valid, 1 - w); end
      end
      ea[w] = AW'($urandom);
      req_addr[w*AW +: AW] = ea[w];
      @(negedge clk);
      checks++; if (req_ready !== '0) begin failures++; $display("FAIL cont_setup_ready%0d got=%b exp=00", g, req_ready); end
      tick;
      checks++; if ({psel, penable} !== 2'b11) begin failures++; $display("FAIL cont_access%0d got=%b%b exp=11", g, psel, penable); end
    end
    req_valid = '0;
    tick;
    checks++; if ({rsp_valid, psel} !== 3'b100) begin failures++; $display("FAIL cont_end got=%b %b exp=10 0", rsp_valid, psel); end
    tick;
  endtask
  task automatic test_back_to_back;
    int n = 0, sel_cnt = 0, sel_runs = 0, rsp_cnt = 0, last_rsp = -1, bad_gap = 0, setups = 0, bad_addr = 0;
    logic prev_sel = 1'b0;
    set_req(0, 1'b1, 1'b1, 8'h00, $urandom);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_ready[0]) n++;
      tick;
      if (n == 3) req_valid[0] = 1'b0;
      else req_addr[0 +: AW] = AW'(n * 4);
      if (psel) sel_cnt++;
      if (psel && !prev_sel) sel_runs++;
      prev_sel = psel;
      if (psel && !penable) begin
        if (paddr !== AW'(setups * 4)) bad_addr++;
        setups++;
      end
      if (rsp_valid[0]) begin
        if (last_rsp >= 0 && c - last_rsp != 2) bad_gap++;
        last_rsp = c;
        rsp_cnt++;
      end
    end
    checks++; if (sel_cnt != 6 || sel_runs != 1) begin failures++; $display("FAIL b2b_psel got=%0d cycles %0d runs exp=6 cycles 1 run", sel_cnt, sel_runs); end
    checks++; if (rsp_cnt != 3 || bad_gap != 0) begin failures++; $display("FAIL b2b_rsp got=%0d pulses %0d bad gaps exp=3 pulses 0", rsp_cnt, bad_gap); end
    checks++; if (bad_addr != 0 || setups != 3) begin failures++; $display("FAIL b2b_addr got=%0d bad %0d setups exp=0 bad 3 setups", bad_addr, setups); end
  endtask
  task automatic test_reset_mid;
    set_req(0, 1'b1, 1'b1, 8'h3C, 32'h12345678);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rmid_ready got=%b exp=01", req_ready); end
    tick;
    req_valid = '0;
    tick;
    rst = 1'b1;
    req_valid = '1;
    @(negedge clk);
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL rmid_ready_in_rst got=%b exp=00", req_ready); end
    tick;
    checks++; if ({psel, penable, paddr, rsp_valid} !== '0) begin failures++; $display("FAIL rmid_bus got=%b%b %h %b exp=00 00 00", psel, penable, paddr, rsp_valid); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rmid_first got=%b exp=01", req_ready); end
    tick;
    req_valid = '0;
    checks++; if (rsp_valid !== '0) begin failures++; $display("FAIL rmid_no_rsp got=%b exp=00", rsp_valid); end
    tick;
    tick;
    tick;
  endtask
  task automatic test_abandoned;
    int extra = 0, rsps = 0;
    set_req(0, 1'b1, 1'b1, 8'h55, 32'hCAFEF00D);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL aband_ready got=%b exp=01", req_ready); end
    tick;
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 1'b0, 8'hAA, 32'h0);
    @(negedge clk);
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL aband_setup_ready got=%b exp=00", req_ready); end
    tick;
    req_valid[1] = 1'b0;
    checks++; if ({psel, penable, paddr} !== {2'b11, 8'h55}) begin failures++; $display("FAIL aband_access got=%b%b %h exp=11 55", psel, penable, paddr); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (req_ready !== '0) extra++;
      tick;
      if (psel !== 1'b0) extra++;
      if (rsp_valid !== '0) rsps++;
    end
    checks++; if (extra != 0 || rsps != 1) begin failures++; $display("FAIL aband_quiet got=%0d activity %0d rsps exp=0 activity 1 rsp", extra, rsps); end
  endtask
  task automatic test_random;
    int acc [NC+4];
    logic aw [NC+4];
    logic [AW-1:0] aa [NC+4];
    logic [DW-1:0] ad [NC+4];
    logic [DW-1:0] prd [NC+4];
    logic [AW+DW+2:0] exp_bus;
    logic [N-1:0] exp_rv;
    logic [DW-1:0] exp_rd = '0;
    int last = N - 1, win;
    for (int i = 0; i < NC + 4; i++) acc[i] = -1;
    rst = 1'b1;
    req_valid = '0;
    tick;
    rst = 1'b0;
    for (int c = 0; c < NC; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(2) == 0) set_req(i, 1'b1, 1'($urandom_range(1)), AW'($urandom), $urandom);
        else if (req_valid[i] && $urandom_range(7) == 0) req_valid[i] = 1'b0;
      prdata = $urandom;
      prd[c+3] = prdata;
      win = -1;
      if (acc[c+2] < 0)
        for (int k = 1; k <= N; k++)
          if (win < 0 && req_valid[(last + k) % N]) win = (last + k) % N;
      @(negedge clk);
      checks++; if (req_ready !== (win < 0 ? N'(0) : N'(1 << win))) begin failures++; $display("FAIL rnd_ready c=%0d got=%b exp_winner=%0d", c, req_ready, win); end
      acc[c+3] = win;
      if (win >= 0) begin
        last = win;
        aw[c+3] = req_write[win];
        aa[c+3] = req_addr[win*AW +: AW];
        ad[c+3] = req_wdata[win*DW +: DW];
      end
      tick;
      if (win >= 0) req_valid[win] = 1'b0;
      if (acc[c+3] >= 0) exp_bus = {2'b10, aw[c+3], aa[c+3], ad[c+3]};
      else if (acc[c+2] >= 0) exp_bus = {2'b11, aw[c+2], aa[c+2], ad[c+2]};
      else exp_bus = '0;
      exp_rv = acc[c+1] >= 0 ? N'(1 << acc[c+1]) : N'(0);
      if (acc[c+1] >= 0) exp_rd = aw[c+1] ? '0 : prd[c+3];
      checks++; if ({psel, penable, pwrite, paddr, pwdata} !== exp_bus) begin failures++; $display("FAIL rnd_bus c=%0d got=%h exp=%h", c, {psel, penable, pwrite, paddr, pwdata}, exp_bus); end
      checks++; if ({rsp_valid, rsp_rdata} !== {exp_rv, exp_rd}) begin failures++; $display("FAIL rnd_rsp c=%0d got=%b %h exp=%b %h", c, rsp_valid, rsp_rdata, exp_rv, exp_rd); end
    end
    req_valid = '0;
    tick;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset;
    test_single_write;
    test_single_read;
    test_contention;
    test_back_to_back;
    test_reset_mid;
    test_abandoned;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
